// File: rtl/fifo_apb_ctrl.sv
// APB master that streams bytes into an APB FIFO peripheral and pops them back out to a stream.
// Optional macro FIFO_APB_CTRL_RR_EN: alternate read/write when both are eligible (default: read first).
module fifo_apb_ctrl #(
  parameter int unsigned PREADY_TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        en,
  input  logic        err_clr,
  output logic        err,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready
);

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_WDATA  = 4'h4;
  localparam logic [3:0] ADDR_RDATA  = 4'h8;
  localparam logic [7:0] TMO_LAST    = 8'(PREADY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ST_SETUP, ST_ACCESS, DECIDE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS
  } state_t;

  state_t      r_state;
  logic [7:0]  r_tmo_cnt;
  logic        r_full;
  logic        r_empty;
  logic        r_err;
  logic [3:0]  r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic        r_psel;
  logic        r_penable;
  logic        r_m_valid;
  logic [7:0]  r_m_data;

  logic w_in_access;
  logic w_timeout;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_pick_rd;
  logic w_xfer_done;
  logic w_unused_prdata;

  assign w_in_access = (r_state == ST_ACCESS) || (r_state == WR_ACCESS) || (r_state == RD_ACCESS);
  assign w_timeout   = w_in_access && !PREADY && (r_tmo_cnt == TMO_LAST);
  assign w_wr_ok     = s_valid && !r_full;
  assign w_rd_ok     = !r_m_valid && !r_empty;
  assign w_xfer_done = ((r_state == WR_ACCESS) || (r_state == RD_ACCESS)) && PREADY;
  assign w_unused_prdata = ^PRDATA[31:8];

`ifdef FIFO_APB_CTRL_RR_EN
  logic r_rr_rd;
  assign w_pick_rd = w_rd_ok && (!w_wr_ok || r_rr_rd);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)         r_rr_rd <= 1'b1;
    else if (w_xfer_done) r_rr_rd <= !r_rr_rd;
  end
`else
  assign w_pick_rd = w_rd_ok;
`endif

  // s_ready is decoded rather than registered so it marks the exact edge the write completes.
  assign s_ready = (r_state == WR_ACCESS) && PREADY;

  assign err     = r_err;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PWRITE  = r_pwrite;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_tmo_cnt <= 8'd0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_err     <= 1'b0;
      r_paddr   <= 4'h0;
      r_pwdata  <= 32'h0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= 8'h0;
    end else begin
      if (r_m_valid && m_ready) r_m_valid <= 1'b0;

      if (w_timeout)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      if (w_in_access) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      else             r_tmo_cnt <= 8'd0;

      if (w_timeout) begin
        r_state   <= IDLE;
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (en && (s_valid || !r_m_valid)) begin
              r_state  <= ST_SETUP;
              r_psel   <= 1'b1;
              r_paddr  <= ADDR_STATUS;
              r_pwrite <= 1'b0;
            end
          end
          ST_SETUP: begin
            r_state   <= ST_ACCESS;
            r_penable <= 1'b1;
          end
          ST_ACCESS: begin
            if (PREADY) begin
              r_full    <= PRDATA[1];
              r_empty   <= PRDATA[0];
              r_state   <= DECIDE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
          DECIDE: begin
            if (!en) begin
              r_state <= IDLE;
            end else if (w_pick_rd) begin
              r_state  <= RD_SETUP;
              r_psel   <= 1'b1;
              r_paddr  <= ADDR_RDATA;
              r_pwrite <= 1'b0;
            end else if (w_wr_ok) begin
              r_state  <= WR_SETUP;
              r_psel   <= 1'b1;
              r_paddr  <= ADDR_WDATA;
              r_pwrite <= 1'b1;
              r_pwdata <= {24'h0, s_data};
            end else begin
              r_state <= IDLE;
            end
          end
          WR_SETUP, RD_SETUP: begin
            r_state   <= (r_state == WR_SETUP) ? WR_ACCESS : RD_ACCESS;
            r_penable <= 1'b1;
          end
          WR_ACCESS: begin
            if (PREADY) begin
              r_state   <= IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
          RD_ACCESS: begin
            if (PREADY) begin
              r_m_data  <= PRDATA[7:0];
              r_m_valid <= 1'b1;
              r_state   <= IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_apb_ctrl.sv
// Self-checking bench for fifo_apb_ctrl: APB FIFO slave model plus an end-to-end stream scoreboard.
module tb_fifo_apb_ctrl;

  localparam int SLV_DEPTH = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        en;
  logic        err_clr;
  logic        err;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;

  fifo_apb_ctrl #(.PREADY_TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .err_clr(err_clr), .err(err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  byte unsigned slv_q[$];   // contents of the APB FIFO peripheral
  byte unsigned src_q[$];   // bytes waiting on the push stream
  byte unsigned sb_q[$];    // bytes expected next on the pop stream, in order
  int           xfer_q[$];  // every completed APB transfer address
  int           data_q[$];  // completed data transfer addresses only
  logic [31:0]  wr_log[$];
  int           exp_seq[$];

  int lat_st, lat_dat, cur_lat, wait_cnt, mr_mode;
  int sready_cnt, rx_cnt, first_setup_cyc, last_sready_cyc;
  bit hang, rand_lat, status_seen, prev_psel, prev_hold;
  logic [7:0]  prev_mdata;
  logic [3:0]  su_addr;
  logic        su_wr;
  logic [31:0] su_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_in(input int q[$], input int a);
    int n = 0;
    foreach (q[i]) if (q[i] == a) n++;
    return n;
  endfunction

  // Order of data transfers the controller should issue, from FIFO occupancy and pending pushes,
  // assuming the pop stream always accepts.
  task automatic build_expected(input int slv, input int src);
    bit rd_next, rd_ok, wr_ok, do_rd;
    rd_next = 1'b1;
    exp_seq.delete();
    while (slv > 0 || src > 0) begin
      rd_ok = (slv > 0);
      wr_ok = (src > 0) && (slv < SLV_DEPTH);
`ifdef FIFO_APB_CTRL_RR_EN
      do_rd = rd_ok && (!wr_ok || rd_next);
`else
      do_rd = rd_ok;
`endif
      if (do_rd) begin
        slv--;
        exp_seq.push_back(8);
      end else if (wr_ok) begin
        src--;
        slv++;
        exp_seq.push_back(4);
      end else break;
      rd_next = !rd_next;
    end
  endtask

  // One clock: answer the APB bus, drive the streams, score handshakes, then advance to edge+1.
  task automatic tick();
    PREADY = 1'b0;
    PRDATA = $urandom();
    if (PSEL && !PENABLE) begin
      check("apb_idle_gap", prev_psel, 0);
      su_addr  = PADDR;
      su_wr    = PWRITE;
      su_wdata = PWDATA;
      wait_cnt = 0;
      cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : ((PADDR == 4'h0) ? lat_st : lat_dat);
      if (PADDR == 4'h0) begin
        if (first_setup_cyc < 0) first_setup_cyc = cyc;
      end else begin
        check("status_before_data", status_seen, 1);
        status_seen = 1'b0;
        if (PADDR == 4'h8) check("no_read_while_valid", m_valid, 0);
      end
    end
    if (PSEL && PENABLE) begin
      check("apb_stable", {PADDR, PWRITE, PWDATA}, {su_addr, su_wr, su_wdata});
      if (PADDR == 4'h0) PRDATA[1:0] = {slv_q.size() == SLV_DEPTH, slv_q.size() == 0};
      else if (PADDR == 4'h8 && slv_q.size() > 0) PRDATA[7:0] = slv_q[0];
      if (!hang && wait_cnt >= cur_lat) begin
        PREADY = 1'b1;
        xfer_q.push_back(int'(PADDR));
        if (PADDR == 4'h4) begin
          check("write_not_full", slv_q.size() < SLV_DEPTH, 1);
          slv_q.push_back(PWDATA[7:0]);
          data_q.push_back(4);
          wr_log.push_back(PWDATA);
        end else if (PADDR == 4'h8) begin
          check("read_not_empty", slv_q.size() > 0, 1);
          if (slv_q.size() > 0) void'(slv_q.pop_front());
          data_q.push_back(8);
        end else begin
          status_seen = 1'b1;
        end
      end else begin
        wait_cnt++;
      end
    end
    s_valid = (src_q.size() > 0);
    s_data  = s_valid ? src_q[0] : 8'($urandom());
    case (mr_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (s_ready) begin
      check("s_ready_with_valid", s_valid, 1);
      if (src_q.size() > 0) sb_q.push_back(src_q.pop_front());
      sready_cnt++;
      last_sready_cyc = cyc;
    end
    if (prev_hold) check("m_hold", {m_valid, m_data}, {1'b1, prev_mdata});
    if (m_valid && m_ready) begin
      if (sb_q.size() > 0) check("m_data_order", m_data, sb_q.pop_front());
      else check("m_data_unexpected", m_valid, 0);
      rx_cnt++;
    end
    prev_hold  = m_valid && !m_ready;
    prev_mdata = m_data;
    prev_psel  = PSEL;
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    en = 1'b0; err_clr = 1'b0; hang = 1'b0; rand_lat = 1'b0;
    lat_st = 0; lat_dat = 0; cur_lat = 0; wait_cnt = 0; mr_mode = 0;
    slv_q.delete(); src_q.delete(); sb_q.delete();
    xfer_q.delete(); data_q.delete(); wr_log.delete();
    sready_cnt = 0; rx_cnt = 0; first_setup_cyc = -1; last_sready_cyc = -1;
    status_seen = 1'b0; prev_hold = 1'b0; prev_psel = 1'b0;
  endtask

  task automatic apply_reset();
    PRESETn = 1'b0;
    clear_model();
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic preload(input byte unsigned b);
    slv_q.push_back(b);
    sb_q.push_back(b);
  endtask

  initial begin
    int acc, st0;
    PRESETn = 1'b0; PREADY = 1'b0; PRDATA = 32'h0;
    s_valid = 1'b0; s_data = 8'h0; m_ready = 1'b0;
    clear_model();
    tick();
    tick();

    // reset state
    check("rst_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("rst_apb_addr_data", {PADDR, PWDATA}, 36'h0);
    check("rst_stream", {s_ready, m_valid, m_data}, 10'h0);
    check("rst_err", err, 0);
    PRESETn = 1'b1;
    tick();

    // single push: status with immediate PREADY, write with one wait cycle
    lat_st = 0; lat_dat = 1;
    src_q.push_back(8'hA5);
    en = 1'b1;
    for (int i = 0; i < 40 && sready_cnt == 0; i++) tick();
    check("push_handshake", sready_cnt, 1);
    check("push_latency", last_sready_cyc - first_setup_cyc + 1, 6);
    check("push_write_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("push_pwdata", wr_log[0], 32'h0000_00A5);
    en = 1'b0;
    repeat (5) tick();
    check("push_single_pulse", sready_cnt, 1);

    // pop into the holding register, held while m_ready is low
    apply_reset();
    preload(8'h3C);
    preload(8'h11);
    en = 1'b1;
    for (int i = 0; i < 40 && !m_valid; i++) tick();
    check("pop_valid", m_valid, 1);
    check("pop_data", m_data, 8'h3C);
    repeat (10) tick();
    check("pop_no_extra_read", n_in(data_q, 8), 1);
    check("pop_still_held", {m_valid, m_data}, {1'b1, 8'h3C});
    en = 1'b0;
    mr_mode = 1;
    tick();
    tick();
    check("pop_consumed", rx_cnt, 1);
    check("pop_cleared", m_valid, 0);

    // full FIFO with the holding register occupied: only status polling
    apply_reset();
    for (int b = 0; b < SLV_DEPTH; b++) preload(8'(8'h10 + b));
    en = 1'b1;
    for (int i = 0; i < 40 && !m_valid; i++) tick();
    check("full_first_read", m_valid, 1);
    preload(8'h14);
    src_q.push_back(8'h77);
    st0 = n_in(xfer_q, 0);
    repeat (40) tick();
    check("full_no_write", n_in(data_q, 4), 0);
    check("full_no_sready", sready_cnt, 0);
    check("full_status_repeat", (n_in(xfer_q, 0) - st0) >= 3, 1);
    check("full_hold", m_valid, 1);

    // read/write contention
    apply_reset();
    for (int b = 0; b < 3; b++) preload(8'(8'h20 + b));
    for (int b = 0; b < 3; b++) src_q.push_back(8'(8'h30 + b));
    build_expected(3, 3);
    mr_mode = 1;
    en = 1'b1;
    for (int i = 0; i < 400 && data_q.size() < exp_seq.size(); i++) tick();
    check("contention_count", data_q.size(), exp_seq.size());
    foreach (exp_seq[i]) if (i < data_q.size()) check($sformatf("contention_xfer%0d", i), data_q[i], exp_seq[i]);
    repeat (20) tick();
    check("contention_drained", rx_cnt, 6);
    en = 1'b0;

    // PREADY timeout, sticky err, clear, and set-over-clear
    apply_reset();
    hang = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 10 && !(PSEL && PENABLE); i++) tick();
    acc = 0;
    while (PSEL && PENABLE && acc < 40) begin
      acc++;
      tick();
    end
    check("timeout_len", acc, 16);
    check("timeout_bus_drop", {PSEL, PENABLE}, 2'b00);
    check("timeout_err", err, 1);
    check("timeout_no_side_effect", {sready_cnt[7:0], m_valid}, 9'h0);
    en = 1'b0;
    repeat (3) tick();
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", err, 0);
    en = 1'b1;
    err_clr = 1'b1;
    for (int i = 0; i < 10 && !(PSEL && PENABLE); i++) tick();
    acc = 0;
    while (PSEL && PENABLE && acc < 40) begin
      acc++;
      tick();
    end
    check("err_set_wins", err, 1);
    err_clr = 1'b0;
    en = 1'b0;
    hang = 1'b0;
    tick();

    // asynchronous reset during WR_ACCESS
    apply_reset();
    lat_dat = 6;
    src_q.push_back(8'h5A);
    en = 1'b1;
    for (int i = 0; i < 30 && !(PSEL && PENABLE && PWRITE); i++) tick();
    check("wr_access_reached", PSEL && PENABLE && PWRITE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_bus", {PSEL, PENABLE}, 2'b00);
    check("rst_mid_sready", s_ready, 0);
    @(posedge PCLK);
    #1;
    en = 1'b0;
    prev_hold = 1'b0;
    prev_psel = 1'b0;
    PRESETn = 1'b1;
    tick();
    tick();
    check("rst_mid_no_pulse", sready_cnt, 0);
    check("rst_mid_no_commit", slv_q.size(), 0);
    check("rst_mid_m_valid", m_valid, 0);

    // randomized traffic: latency, pop back-pressure and enable all vary
    apply_reset();
    rand_lat = 1'b1;
    mr_mode = 2;
    for (int b = 0; b < 24; b++) src_q.push_back(8'($urandom()));
    en = 1'b1;
    for (int i = 0; i < 4000 && rx_cnt < 24; i++) begin
      if (i % 32 == 31) en = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_all_received", rx_cnt, 24);
    check("rand_src_drained", src_q.size(), 0);
    check("rand_no_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_apb_ctrl.md
FIFO_APB_CTRL -- requirements
Module: fifo_apb_ctrl

Interface
REQ-001 SHALL have parameter: PREADY_TIMEOUT, 16, max ACCESS-phase cycles waited for PREADY before abort (range 2..255).
REQ-002 SHALL have ports (name direction width meaning):
- PCLK  in  1  sole clock, all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- en  in  1  scheduler enable
- err_clr  in  1  clears err
- err  out  1  sticky PREADY-timeout flag
- PADDR  out  4  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- s_valid  in  1  push-stream valid
- s_data  in  8  push byte
- s_ready  out  1  push accepted (1-cycle pulse)
- m_valid  out  1  pop-stream valid
- m_data  out  8  pop byte
- m_ready  in  1  pop-stream ready

Function
REQ-003 SHALL be an APB master that sequences the FIFO peripheral: byte stream in -> FIFO write, FIFO read -> byte stream out.
REQ-004 Register map SHALL be: 0x0 status (PRDATA[1]=full, PRDATA[0]=empty), 0x4 write data (PWDATA={24'h0,byte}), 0x8 read data (PRDATA[7:0], pop side effect).
REQ-005 FSM states SHALL be IDLE, ST_SETUP, ST_ACCESS, DECIDE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS.
REQ-006 Each transfer SHALL be 1 SETUP cycle (PSEL=1,PENABLE=0) then ACCESS (PSEL=1,PENABLE=1) held until PREADY=1; PADDR/PWDATA/PWRITE stable over SETUP+ACCESS.
REQ-007 After every completed transfer PSEL SHALL be 0 for at least 1 cycle (IDLE or DECIDE).
REQ-008 IDLE -> ST_SETUP when en=1 and (s_valid=1 or m_valid=0); else stay IDLE with PSEL=0.
REQ-009 ST_ACCESS with PREADY SHALL latch full/empty and go to DECIDE.
REQ-010 DECIDE SHALL mark write eligible if s_valid=1 and full=0, read eligible if m_valid=0 and empty=0; neither -> IDLE.
REQ-011 WR_SETUP SHALL capture s_data into PWDATA[7:0]; s_ready SHALL pulse for exactly the cycle WR_ACCESS sees PREADY=1; then IDLE.
REQ-012 RD_ACCESS with PREADY SHALL load m_data<=PRDATA[7:0], set m_valid next cycle, then IDLE.
REQ-013 m_valid SHALL hold with m_data stable until m_valid&&m_ready, then clear; no read issued while m_valid=1 (1-entry holding register, no overflow).
REQ-014 Every transfer SHALL be preceded by a fresh status read; at most one data transfer per status read.
REQ-015 A timeout counter SHALL run in any ACCESS state; reaching PREADY_TIMEOUT cycles without PREADY SHALL drop PSEL/PENABLE, set err, go IDLE, no s_ready pulse, m_valid unchanged.
REQ-016 err SHALL stay 1 until err_clr=1; err_clr and a new timeout in the same cycle SHALL leave err=1.
REQ-017 en=0 mid-transfer SHALL let the current transfer complete; FSM then parks in IDLE.

Reset
REQ-018 PRESETn=0 SHALL asynchronously force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, s_ready=0, m_valid=0, m_data=0, err=0, timeout counter 0, round-robin pointer to "read".
REQ-019 Reset mid-transfer SHALL abort immediately; captured-but-unissued byte dropped, s_ready not pulsed.

Configuration
REQ-020 Macro FIFO_APB_CTRL_RR_EN defined: read and write both eligible in DECIDE SHALL alternate, starting with read, pointer toggling on each completed data transfer.
REQ-021 Macro undefined: read SHALL have fixed priority over write when both eligible.

Verification
REQ-022 Single push: en=1, s_valid=1, s_data=0xA5, status 0b00 -> APB write addr 0x4 PWDATA=0x000000A5, one s_ready pulse, 6 cycles status-to-write-done with 1-cycle-late PREADY.
REQ-023 Pop: FIFO holds 0x3C, m_ready=0 -> status, read 0x8, m_valid=1 m_data=0x3C held 10 cycles; no further 0x8 reads until m_ready=1.
REQ-024 Full: status 0b10, s_valid=1, m_valid=1 -> only status reads repeat, no 0x4 write, s_ready stays 0.
REQ-025 Contention (RR_EN defined): FIFO non-empty not full, s_valid=1, m_ready=1 -> data transfers alternate 0x8,0x4,0x8,0x4; without macro all reads first until empty=1.
REQ-026 Timeout: PREADY held 0 -> PSEL drops after 16 ACCESS cycles, err=1; err_clr=1 -> err=0 next cycle.
REQ-027 Reset in WR_ACCESS: PRESETn=0 -> PSEL=0 same cycle, no s_ready, m_valid=0 after release.
